// File: rtl/seq_muldiv_unit.sv
// seq_muldiv_unit: iterative 33-bit signed multiply (add/shift) and restoring divide,
// one iteration per clock, with a final sign-fix cycle for divide results.
module seq_muldiv_unit (
   input  logic        Clk,
   input  logic        Reset,
   input  logic        Run,
   input  logic [32:0] opA,
   input  logic [32:0] opB,
   input  logic        div,
   input  logic        stall,
   output logic [32:0] Aval,
   output logic [32:0] Bval,
   output logic        resp,
   output logic        ready
);
   typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;
   state_t state, state_n;
   logic [33:0] a, s, t, mext;
   logic [32:0] b, mcand, dsor;
   logic [5:0]  cnt;
   logic        is_div, neg_q, neg_r, arm, start, ge;
   assign start = state == IDLE && Run && arm;
   assign mext  = {mcand[32], mcand};
   // the final multiplier bit carries negative weight, so it subtracts
   assign s     = ~b[0] ? a : (cnt == 6'd1) ? a - mext : a + mext;
   assign t     = {a[32:0], b[32]};
   assign ge    = t >= {1'b0, dsor};
   assign Aval  = a[32:0];
   assign Bval  = b;
   assign resp  = state == DONE;
   assign ready = state == IDLE;
   always_ff @(posedge Clk or posedge Reset)
      if (Reset) state <= IDLE;
      else       state <= state_n;
   always_comb begin
      state_n = state;
      case (state)
         IDLE:    state_n = start ? CALC : IDLE;
         CALC:    state_n = (cnt == 6'd0) ? FIX : CALC;
         FIX:     state_n = DONE;
         DONE:    state_n = stall ? DONE : IDLE;
         default: state_n = IDLE;
      endcase
   end
   always_ff @(posedge Clk or posedge Reset)
      if (Reset) begin
         a      <= '0;
         b      <= '0;
         mcand  <= '0;
         dsor   <= '0;
         cnt    <= '0;
         is_div <= 1'b0;
         neg_q  <= 1'b0;
         neg_r  <= 1'b0;
         arm    <= 1'b1;
      end else begin
         if (!Run) arm <= 1'b1;
         if (start) begin
            arm    <= 1'b0;
            cnt    <= 6'd33;
            mcand  <= opA;
            dsor   <= opB[32] ? -opB : opB;
            is_div <= div;
            neg_q  <= div && (opA[32] ^ opB[32]) && opB != '0;
            neg_r  <= div && opA[32];
            a      <= '0;
            b      <= div ? (opA[32] ? -opA : opA) : opB;
         end else if (state == CALC && cnt != 6'd0) begin
            cnt <= cnt - 6'd1;
            a   <= is_div ? (ge ? t - {1'b0, dsor} : t) : {s[33], s[33:1]};
            b   <= is_div ? {b[31:0], ge} : {s[0], b[32:1]};
         end else if (state == FIX) begin
            a <= neg_r ? -a : a;
            b <= neg_q ? -b : b;
         end
      end
endmodule

// File: tb/tb_seq_muldiv_unit.sv
// tb_seq_muldiv_unit: cycle-level reference model with a per-cycle compare process,
// plus directed operations checked against hand-computed results.
module tb_seq_muldiv_unit;
   logic        Clk, Reset, Run, div, stall;
   logic [32:0] opA, opB, Aval, Bval;
   logic        resp, ready;
   int total = 0, bad = 0;

   seq_muldiv_unit dut (
      .Clk(Clk), .Reset(Reset), .Run(Run), .opA(opA), .opB(opB), .div(div),
      .stall(stall), .Aval(Aval), .Bval(Bval), .resp(resp), .ready(ready)
   );

   initial begin
      Clk = 0;
      forever #5 Clk = ~Clk;
   end

   task automatic chk(input string nm, input logic [32:0] got, input logic [32:0] want);
      total++;
      if (got !== want) begin
         bad++;
         $display("FAIL %s: got %h want %h", nm, got, want);
      end
   endtask

   // Result as {upper33, lower33}: product, or {remainder, quotient}.
   function automatic logic [65:0] ref_result(input logic [32:0] x, input logic [32:0] y, input bit d);
      logic signed [65:0] p;
      longint sx, sy, q, r;
      logic [63:0] qb, rb;
      if (!d) begin
         p = $signed({{33{x[32]}}, x}) * $signed({{33{y[32]}}, y});
         return p;
      end
      sx = longint'($signed(x));
      sy = longint'($signed(y));
      if (y == '0) begin
         q = -1;
         r = sx;
      end else begin
         q = sx / sy;
         r = sx % sy;
      end
      qb = q;
      rb = r;
      return {rb[32:0], qb[32:0]};
   endfunction

   int          m_left = 0;
   bit          m_done = 0, m_arm = 1;
   logic [32:0] m_a = '0, m_b = '0;
   logic [65:0] m_res = '0;

   always @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         m_left = 0;
         m_done = 0;
         m_arm  = 1;
         m_a    = '0;
         m_b    = '0;
      end else begin
         if (!Run) m_arm = 1;
         if (m_done) m_done = stall;
         else if (m_left > 0) begin
            m_left--;
            if (m_left == 0) begin
               m_done = 1;
               m_a    = m_res[65:33];
               m_b    = m_res[32:0];
            end
         end else if (Run && m_arm) begin
            m_arm  = 0;
            m_left = 35;
            m_res  = ref_result(opA, opB, div);
         end
      end
   end

   always @(negedge Clk) begin
      if (!Reset) begin
         chk("model_ready", {32'd0, ready}, {32'd0, (m_left == 0 && !m_done)});
         chk("model_resp", {32'd0, resp}, {32'd0, m_done});
         if (ready || resp) begin
            chk("model_Aval", Aval, m_a);
            chk("model_Bval", Bval, m_b);
         end
      end
   end

   task automatic run_op(input logic [32:0] x, input logic [32:0] y, input bit d,
                         input logic [32:0] ea, input logic [32:0] eb, input bit keep_run,
                         input string nm);
      int n;
      opA = x;
      opB = y;
      div = d;
      Run = 1;
      @(posedge Clk);
      #1;
      Run = keep_run;
      opA = ~x;
      opB = ~y;
      div = ~d;
      n = 0;
      while (!resp && n < 60) begin
         @(posedge Clk);
         #1;
         n++;
      end
      chk({nm, "_lat"}, 33'(n), 33'd35);
      chk({nm, "_A"}, Aval, ea);
      chk({nm, "_B"}, Bval, eb);
   endtask

   task automatic op(input logic [32:0] x, input logic [32:0] y, input bit d,
                     input logic [32:0] ea, input logic [32:0] eb, input string nm);
      run_op(x, y, d, ea, eb, 1'b0, nm);
      @(posedge Clk);
      #1;
   endtask

   initial begin
      Reset = 1;
      Run   = 0;
      div   = 0;
      stall = 0;
      opA   = '0;
      opB   = '0;
      #1;
      chk("rst_ready", {32'd0, ready}, 33'd1);
      chk("rst_resp", {32'd0, resp}, 33'd0);
      chk("rst_A", Aval, 33'd0);
      chk("rst_B", Bval, 33'd0);
      repeat (2) @(posedge Clk);
      #1;
      Reset = 0;
      @(posedge Clk);
      #1;

      op(33'd3, 33'd5, 0, 33'd0, 33'hF, "mul_3x5");
      op(33'h1_FFFF_FFFD, 33'd5, 0, 33'h1_FFFF_FFFF, 33'h1_FFFF_FFF1, "mul_m3x5");
      op(33'h1_FFFF_FFFF, 33'h1_FFFF_FFFF, 0, 33'd0, 33'd1, "mul_m1xm1");
      op(33'h0_FFFF_FFFF, 33'h0_FFFF_FFFF, 0, 33'h0_7FFF_FFFF, 33'd1, "mul_umax");
      op(33'd7, 33'd2, 1, 33'd1, 33'd3, "div_7_2");
      op(33'h1_FFFF_FFF9, 33'd2, 1, 33'h1_FFFF_FFFF, 33'h1_FFFF_FFFD, "div_m7_2");
      op(33'd7, 33'h1_FFFF_FFFE, 1, 33'd1, 33'h1_FFFF_FFFD, "div_7_m2");
      op(33'd100, 33'd7, 1, 33'd2, 33'd14, "div_100_7");
      op(33'd5, 33'd0, 1, 33'd5, 33'h1_FFFF_FFFF, "div_5_0");
      op(33'h1_FFFF_FFFB, 33'd0, 1, 33'h1_FFFF_FFFB, 33'h1_FFFF_FFFF, "div_m5_0");
      op(33'h1_8000_0000, 33'h1_FFFF_FFFF, 1, 33'd0, 33'h0_8000_0000, "div_ovf");

      stall = 1;
      run_op(33'd6, 33'd7, 0, 33'd0, 33'd42, 1'b0, "stall_mul");
      for (int i = 0; i < 4; i++) begin
         @(posedge Clk);
         #1;
         if (i == 3) stall = 0;
         chk("stall_resp", {32'd0, resp}, 33'd1);
         chk("stall_B", Bval, 33'd42);
      end
      @(posedge Clk);
      #1;
      chk("stall_exit_ready", {32'd0, ready}, 33'd1);
      chk("stall_exit_resp", {32'd0, resp}, 33'd0);
      chk("stall_hold_B", Bval, 33'd42);

      opA = 33'd9;
      opB = 33'd9;
      div = 0;
      Run = 1;
      @(posedge Clk);
      #1;
      Run = 0;
      repeat (10) @(posedge Clk);
      #1;
      Reset = 1;
      #1;
      chk("abort_ready", {32'd0, ready}, 33'd1);
      chk("abort_resp", {32'd0, resp}, 33'd0);
      chk("abort_A", Aval, 33'd0);
      chk("abort_B", Bval, 33'd0);
      #1;
      Reset = 0;
      @(posedge Clk);
      #1;

      run_op(33'd4, 33'd4, 0, 33'd0, 33'd16, 1'b1, "hold_run");
      for (int i = 0; i < 5; i++) begin
         @(posedge Clk);
         #1;
         chk("no_restart", {32'd0, ready}, 33'd1);
      end
      Run = 0;
      @(posedge Clk);
      #1;
      op(33'd12, 33'd5, 1, 33'd2, 33'd2, "rearm_div");

      repeat (3) @(posedge Clk);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
